// File: rtl/openip_stream_downsizer_if.sv
// Stream bundle for openip_stream_downsizer: wide write side (w_*) and narrow
// read side (r_*). The slave modport is the downsizer's view, the master
// modport is the view of whatever drives and consumes it.
// Optional per-word last flag: OPENIP_DOWNSIZER_LAST_EN.
interface openip_stream_downsizer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    localparam int LW = $clog2(RATIO);

    logic                        w_valid;
    logic                        w_ready;
    logic [DATA_WIDTH*RATIO-1:0] w_data;
    logic [LW-1:0]               w_lanes;
    logic                        r_valid;
    logic                        r_ready;
    logic [DATA_WIDTH-1:0]       r_data;
`ifdef OPENIP_DOWNSIZER_LAST_EN
    logic                        w_last;
    logic                        r_last;

    modport slave (
        input  w_valid, w_data, w_lanes, w_last, r_ready,
        output w_ready, r_valid, r_data, r_last
    );
    modport master (
        output w_valid, w_data, w_lanes, w_last, r_ready,
        input  w_ready, r_valid, r_data, r_last
    );
`else
    modport slave (
        input  w_valid, w_data, w_lanes, r_ready,
        output w_ready, r_valid, r_data
    );
    modport master (
        output w_valid, w_data, w_lanes, r_ready,
        input  w_ready, r_valid, r_data
    );
`endif
endinterface

// File: rtl/openip_stream_downsizer.sv
// openip_stream_downsizer: splits one wide word of RATIO lanes into RATIO
// (or fewer, via w_lanes) narrow beats. Lane order set by MSB_FIRST.
// Optional feature macro: OPENIP_DOWNSIZER_LAST_EN adds w_last/r_last.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// source holds valid and its payload steady until the transfer; ready may
// depend combinationally on the other side (r_ready -> w_ready here, so the
// next word loads on the same edge the final lane leaves).
// RATIO must be at least 2.
module openip_stream_downsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    openip_stream_downsizer_if.slave bus
);
    localparam int LW = $clog2(RATIO);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_BUSY  = 1'b1
    } state_t;

    state_t                      state;
    logic [DATA_WIDTH*RATIO-1:0] hold_data;
    logic [LW-1:0]               hold_lanes;
    logic [LW-1:0]               idx;
    logic [LW-1:0]               sel;
    logic                        valid;
    logic                        fin;
    logic                        w_ready;
    logic                        w_fire;
    logic                        r_fire;
    logic [DATA_WIDTH-1:0]       lanes [RATIO];

    assign valid   = (state == S_BUSY);
    assign fin     = valid && (idx == hold_lanes);
    assign w_ready = !rst && (!valid || (bus.r_ready && fin));
    assign w_fire  = bus.w_valid && w_ready;
    assign r_fire  = valid && bus.r_ready;

    assign bus.w_ready = w_ready;
    assign bus.r_valid = valid;

    // Lane select: idx counts beats already sent; MSB_FIRST mirrors it.
    always_comb begin
        sel = idx;
        if (MSB_FIRST != 0) begin
            sel = LW'(RATIO - 1) - idx;
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lanes[g] = hold_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bus.r_data = lanes[sel];

    // Control FSM: EMPTY/BUSY plus beat counter; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            idx   <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (w_fire) begin
                        state <= S_BUSY;
                        idx   <= '0;
                    end
                end
                S_BUSY: begin
                    if (r_fire) begin
                        if (!fin) begin
                            idx <= idx + LW'(1);
                        end else begin
                            idx   <= '0;
                            state <= w_fire ? S_BUSY : S_EMPTY;
                        end
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Word holding register: loaded only on a write handshake, never reset.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            hold_data  <= bus.w_data;
            hold_lanes <= bus.w_lanes;
        end
    end

`ifdef OPENIP_DOWNSIZER_LAST_EN
    logic hold_last;

    // Last flag travels with the word and is shown only on its final beat.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            hold_last <= bus.w_last;
        end
    end

    assign bus.r_last = fin && hold_last;
`endif

    // A lane count beyond RATIO-1 is only encodable for non-power-of-two RATIO.
    if ((1 << LW) != RATIO) begin : g_lanes_chk
        always_ff @(posedge clk) begin
            if (w_fire) begin
                assert ({1'b0, bus.w_lanes} < (LW+1)'(RATIO));
            end
        end
    end
endmodule

// File: doc/openip_stream_downsizer.md
# openip_stream_downsizer

Valid/ready stream width converter. It accepts one wide word of `RATIO` lanes and emits those lanes one per beat on a narrow stream. Partial words are supported through a lane-count field. The block sits directly upstream of an `openip_regslice` on the narrow side, which supplies any required timing isolation; this block adds no register on the `r_ready`→`w_ready` path.

## Interface
- `DATA_WIDTH`, 8: narrow lane width in bits.
- `RATIO`, 4: lanes per wide word; must be ≥2.
- `MSB_FIRST`, 0: 0 emits lane 0 (bits `[DATA_WIDTH-1:0]`) first; 1 emits lane `RATIO-1` first.
- `LW` (derived, not overridable): `$clog2(RATIO)`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `w_valid`  in  1  wide word offered.
- `w_ready`  out  1  wide word accepted when `w_valid && w_ready`.
- `w_data`  in  `DATA_WIDTH*RATIO`  wide word.
- `w_lanes`  in  `LW`  number of valid lanes minus one (0 means 1 lane, `RATIO-1` means full word).
- `r_valid`  out  1  narrow beat offered.
- `r_ready`  in  1  narrow beat consumed when `r_valid && r_ready`.
- `r_data`  out  `DATA_WIDTH`  narrow beat.
- `w_last` / `r_last`: present only with `OPENIP_DOWNSIZER_LAST_EN` (see Configuration).

## Operation
- State:
  - `hold` register: wide data, lane count, and (optionally) last flag.
  - `valid` flag.
  - `idx` lane counter, `LW` bits.
- States:
  - EMPTY (`valid=0`).
  - BUSY (`valid=1`, `idx` = beats already emitted from `hold`).
- `r_valid = valid`.
- `r_data` = lane `idx` of `hold` (`MSB_FIRST=0`), or lane `RATIO-1-idx` (`MSB_FIRST=1`).
- Final beat: `fin = valid && (idx == hold_lanes)`.
- `w_ready = !rst && (!valid || (r_ready && fin))`.
- EMPTY, on write: capture `w_data`/`w_lanes`, `idx←0`, go to BUSY.
- BUSY, on narrow handshake with `!fin`: `idx←idx+1`.
- BUSY, on narrow handshake with `fin`:
  - Write in the same cycle: capture the new word, `idx←0`, stay BUSY (no bubble).
  - No write: go to EMPTY, `idx←0`.
- Arithmetic:
  - `idx` never exceeds `hold_lanes`, so there is no wrap.
  - `w_lanes` is captured verbatim.
  - Unused lanes of a partial word are never emitted.
- `hold` is loaded only on a write handshake and is stable while BUSY.
- Narrow output is stable under backpressure: `r_valid`/`r_data` are held while `r_valid && !r_ready`.

## Timing
- Reset:
  - `valid=0`, `idx=0`.
  - Outputs: `r_valid=0`, `w_ready=0` while `rst=1`, and `w_ready=1` in the first cycle after reset deasserts.
  - `hold` is not reset.
- Latency: a word accepted at edge N shows its first beat with `r_valid=1` in cycle N+1.
- Throughput:
  - A full word takes `RATIO` narrow beats.
  - Back-to-back words stream with zero idle cycles when `r_ready` stays high.
- Combinational path `r_ready`→`w_ready` exists by design.
- No combinational path `w_valid`/`w_data`→`r_valid`/`r_data`.
- Reset mid-word: the remaining lanes are discarded and the block comes out of reset in EMPTY.
- `w_valid` high during reset is ignored (no capture).
- `w_lanes > RATIO-1` is impossible for `RATIO` a power of two. For other `RATIO` it is illegal and is caught by an assertion in simulation.

## Configuration
- `OPENIP_DOWNSIZER_LAST_EN` defined:
  - Adds `w_last` (in, 1) and `r_last` (out, 1).
  - `w_last` is captured with the word.
  - `r_last = fin && hold_last`: high only on the final narrow beat of a word that was written with `w_last=1`; otherwise 0.
  - `r_last` is 0 after reset.
- Undefined: both ports are absent and there is no `last` storage.

## Test plan
- Full word, LSB first:
  - Setup: `DATA_WIDTH=8`, `RATIO=4`.
  - Stimulus: write `0x44332211` with `w_lanes=3`; `r_ready=1`.
  - Required: `r_data` = 0x11, 0x22, 0x33, 0x44 in cycles 1–4.
  - Required: `w_ready=0` in cycles 1–3 and `=1` in cycle 4.
- Back-to-back:
  - Stimulus: two full words `0x44332211` then `0x88776655`.
  - Required: eight consecutive beats 0x11…0x88 with no gap; second word accepted in the cycle 0x44 is consumed.
- Partial word and backpressure:
  - Stimulus: `w_lanes=1`, data `0xDDCCBBAA`; `r_ready=0` for 3 cycles, then 1.
  - Required: 0xAA held stable for 3 cycles, then 0xBB; 0xCC/0xDD never appear; EMPTY afterwards.
- `MSB_FIRST=1`, full word:
  - Stimulus: write `0x44332211` with `w_lanes=3`.
  - Required: 0x44, 0x33, 0x22, 0x11.
- Reset mid-word:
  - Stimulus: assert `rst` after 0x22 is consumed.
  - Required: `r_valid=0` next cycle; no further beats from that word; `w_ready=1` one cycle after `rst` falls.
- `OPENIP_DOWNSIZER_LAST_EN`:
  - Stimulus: a word with `w_last=0` followed by a word with `w_last=1`, both full.
  - Required: `r_last=1` only on the 8th beat.
